// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared FSM state type and line levels for the serial framer
package serial_tx_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-load shift register presenting one serial bit, LSB- or MSB-first
module piso_shreg #(
    parameter int DATA_W    = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_i,
    output logic              ser_o
);
    logic [DATA_W-1:0] sr_q, sr_d;

    // Load has priority over shift; the exposed bit moves toward the output end
    always_comb sr_d = load ? data_i : shift ? (LSB_FIRST ? sr_q >> 1 : sr_q << 1) : sr_q;

    // Register the shift state
    always_ff @(posedge clk or posedge reset)
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;

    assign ser_o = LSB_FIRST ? sr_q[0] : sr_q[DATA_W-1];
endmodule

// File: rtl/serial_tx_framer.sv
// serial_tx_framer: valid/ready word in, start + data + stop bits out on a registered line
module serial_tx_framer
    import serial_tx_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter bit LSB_FIRST = 1'b1,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              x_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          x_q, x_d, busy_q, busy_d, done_q, done_d;
    logic          ser, accept, shift;

    assign ready_o = (state_q == IDLE) || (state_q == STOP && cnt_q == LAST_STOP);
    assign accept  = valid_i && ready_o;
    assign shift   = (state_q == START) || (state_q == DATA);

    piso_shreg #(.DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_shreg (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .shift  (shift),
        .data_i (data_i),
        .ser_o  (ser)
    );

    // Next state plus next line level, so x_o/done_o/busy_o come straight from flops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                x_d     = START_LEVEL;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                x_d     = ser;
            end
            DATA: if (cnt_q == LAST_DATA) begin
                state_d = STOP;
                cnt_d   = '0;
                x_d     = IDLE_LEVEL;
                done_d  = (LAST_STOP == '0);
            end else begin
                cnt_d = cnt_q + 1'b1;
                x_d   = ser;
            end
            STOP: if (cnt_q == LAST_STOP) begin
                cnt_d   = '0;
                state_d = accept ? START : IDLE;
                x_d     = accept ? START_LEVEL : IDLE_LEVEL;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                x_d    = IDLE_LEVEL;
                done_d = (cnt_q + 1'b1) == LAST_STOP;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM and output registers; reset drops the line to idle immediately
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end

    assign x_o    = x_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_serial_tx_framer.sv
// tb_serial_tx_framer: directed and random frames on two configurations against a frame model
module tb_serial_tx_framer;
    logic       clk = 1'b0;
    logic       rst   [2];
    logic [3:0] data  [2];
    logic       valid [2];
    logic       ready [2];
    logic       x     [2];
    logic       busy  [2];
    logic       done  [2];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    serial_tx_framer #(.DATA_W(4), .LSB_FIRST(1'b1), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(rst[0]), .data_i(data[0]), .valid_i(valid[0]),
        .ready_o(ready[0]), .x_o(x[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    serial_tx_framer #(.DATA_W(4), .LSB_FIRST(1'b0), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(rst[1]), .data_i(data[1]), .valid_i(valid[1]),
        .ready_o(ready[1]), .x_o(x[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    function automatic int stops(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Expected line level i cycles into a frame: start bit, data bits in wire order, stop bits
    function automatic logic exp_bit(input int k, input logic [3:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 4) return (k == 0) ? d[i-1] : d[4-i];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("idle_x k%0d", k), x[k], 1'b1);
            chk($sformatf("idle_ready k%0d", k), ready[k], 1'b1);
            chk($sformatf("idle_busy k%0d", k), busy[k], 1'b0);
            chk($sformatf("idle_done k%0d", k), done[k], 1'b0);
        end
    endtask

    // Caller has presented d with valid at a negedge; checks the whole frame that follows
    task automatic frame(input int k, input logic [3:0] d, input bit chain, input logic [3:0] nd);
        int len;
        len = 5 + stops(k);
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        data[k]  = 4'($urandom);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk($sformatf("x k%0d d%h c%0d", k, d, i), x[k], exp_bit(k, d, i));
            chk($sformatf("done k%0d c%0d", k, i), done[k], i == len - 1);
            chk($sformatf("ready k%0d c%0d", k, i), ready[k], i == len - 1);
            chk($sformatf("busy k%0d c%0d", k, i), busy[k], 1'b1);
            data[k]  = (i == len - 1 && chain) ? nd : 4'($urandom);
            valid[k] = (i < len - 1) ? 1'($urandom) : chain;
        end
    endtask

    task automatic send(input int k, input logic [3:0] d);
        @(negedge clk);
        chk($sformatf("ready_pre k%0d", k), ready[k], 1'b1);
        data[k]  = d;
        valid[k] = 1'b1;
        frame(k, d, 1'b0, 4'h0);
    endtask

    initial begin
        logic [3:0] d1, d2;
        for (int k = 0; k < 2; k++) begin
            rst[k]   = 1'b1;
            valid[k] = 1'b0;
            data[k]  = 4'h0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_x", x[k], 1'b1);
            chk("rst_ready", ready[k], 1'b1);
            chk("rst_busy", busy[k], 1'b0);
            chk("rst_done", done[k], 1'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        idle_chk(0, 20);
        idle_chk(1, 2);

        send(0, 4'b1011);
        idle_chk(0, 2);

        @(negedge clk);
        chk("b2b_ready", ready[0], 1'b1);
        data[0]  = 4'hA;
        valid[0] = 1'b1;
        frame(0, 4'hA, 1'b1, 4'h5);
        frame(0, 4'h5, 1'b0, 4'h0);
        idle_chk(0, 1);

        @(negedge clk);
        data[0]  = 4'h0;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_x_before", x[0], 1'b0);
        chk("mid_busy_before", busy[0], 1'b1);
        #1;
        rst[0] = 1'b1;
        #1;
        chk("mid_x_async", x[0], 1'b1);
        chk("mid_busy_async", busy[0], 1'b0);
        chk("mid_ready_async", ready[0], 1'b1);
        chk("mid_done_async", done[0], 1'b0);
        @(negedge clk);
        rst[0] = 1'b0;
        chk("mid_ready_release", ready[0], 1'b1);
        send(0, 4'h3);
        idle_chk(0, 1);

        send(1, 4'b1000);
        idle_chk(1, 2);

        send(0, 4'b0110);
        idle_chk(0, 1);

        for (int n = 0; n < 8; n++) begin
            d1 = 4'($urandom);
            d2 = 4'($urandom);
            @(negedge clk);
            chk($sformatf("rnd_ready k%0d", n % 2), ready[n % 2], 1'b1);
            data[n % 2]  = d1;
            valid[n % 2] = 1'b1;
            frame(n % 2, d1, 1'b1, d2);
            frame(n % 2, d2, 1'b0, 4'h0);
            idle_chk(n % 2, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
